// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA tile bit generator: tile geometry,
// tile-map word layout, RGB332 colour type and the power-up palette.
package vga_pkg;

  localparam int H_TILES    = 80;
  localparam int V_TILES    = 60;
  localparam int TILE_SHIFT = 3;
  localparam int MAP_AW     = 13;
  localparam int GLYPH_AW   = 11;

  localparam int GLYPH_LSB  = 0;
  localparam int FG_LSB     = 8;
  localparam int BG_LSB     = 12;

  typedef logic [7:0]        rgb332_t;
  typedef logic [3:0]        pal_idx_t;
  typedef rgb332_t [15:0]    pal_t;

  // Entry 15 is white and every other entry black.
  localparam pal_t DEFAULT_PAL = {8'hFF, {15{8'h00}}};

endpackage

// File: rtl/vga_palette.sv
// 16-entry RGB332 palette: one write port, one combinational read port,
// synchronous clear back to the default colours.
module vga_palette
  import vga_pkg::*;
(
  input  logic     clock_i,
  input  logic     clear_i,
  input  logic     we_i,
  input  pal_idx_t wr_idx_i,
  input  rgb332_t  wr_data_i,
  input  pal_idx_t rd_idx_i,
  output rgb332_t  rd_data_o
);

  pal_t mem_q;

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      mem_q <= DEFAULT_PAL;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Reads see the pre-write contents on a write edge.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/vga_tile_bitgen.sv
// Tile-based pixel generator with a fixed 3-cycle pipeline behind the VGA timing
// controller. Optional blinking cursor enabled by defining VGA_BITGEN_CURSOR_EN.
module vga_tile_bitgen
  import vga_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                hSync_in,
  input  logic                vSync_in,
  input  logic                bright_in,
  input  logic [9:0]          hCount,
  input  logic [9:0]          vCount,
  output logic [MAP_AW-1:0]   map_addr,
  input  logic [15:0]         map_data,
  output logic [GLYPH_AW-1:0] glyph_addr,
  input  logic [7:0]          glyph_data,
  input  logic                pal_we,
  input  logic [3:0]          pal_idx,
  input  logic [7:0]          pal_data,
`ifdef VGA_BITGEN_CURSOR_EN
  input  logic [6:0]          cursor_col,
  input  logic [5:0]          cursor_row,
`endif
  output logic [7:0]          rgb,
  output logic                hSync,
  output logic                vSync,
  output logic                bright
);

  logic [MAP_AW-1:0] row_ext, col_ext;

  // row*80 as row*64 + row*16; lines >= 512 never carry active video.
  always_comb begin
    row_ext  = MAP_AW'(vCount[8:TILE_SHIFT]);
    col_ext  = MAP_AW'(hCount[9:TILE_SHIFT]);
    map_addr = '0;
    if (bright_in && !vCount[9]) begin
      map_addr = (row_ext << 6) + (row_ext << 4) + col_ext;
    end
  end

  logic [2:0] a_col_q, a_row_q;
  logic       a_hs_q, a_vs_q, a_br_q, a_swap_q, a_swap_d;

`ifdef VGA_BITGEN_CURSOR_EN
  logic [5:0] frame_q;
  logic       vs_prev_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      frame_q   <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      vs_prev_q <= vSync_in;
      if (vs_prev_q && !vSync_in) frame_q <= frame_q + 6'd1;
    end
  end

  assign a_swap_d = frame_q[5] && (hCount[9:TILE_SHIFT] == cursor_col) &&
                    (vCount[8:TILE_SHIFT] == cursor_row);
`else
  assign a_swap_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      a_col_q  <= '0;
      a_row_q  <= '0;
      a_hs_q   <= 1'b1;
      a_vs_q   <= 1'b1;
      a_br_q   <= 1'b0;
      a_swap_q <= 1'b0;
    end else begin
      a_col_q  <= hCount[TILE_SHIFT-1:0];
      a_row_q  <= vCount[TILE_SHIFT-1:0];
      a_hs_q   <= hSync_in;
      a_vs_q   <= vSync_in;
      a_br_q   <= bright_in;
      a_swap_q <= a_swap_d;
    end
  end

  assign glyph_addr = {map_data[GLYPH_LSB +: 8], a_row_q};

  logic [3:0] b_fg_q, b_bg_q;
  logic [2:0] b_col_q;
  logic       b_hs_q, b_vs_q, b_br_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      b_fg_q  <= '0;
      b_bg_q  <= '0;
      b_col_q <= '0;
      b_hs_q  <= 1'b1;
      b_vs_q  <= 1'b1;
      b_br_q  <= 1'b0;
    end else begin
      b_fg_q  <= a_swap_q ? map_data[BG_LSB +: 4] : map_data[FG_LSB +: 4];
      b_bg_q  <= a_swap_q ? map_data[FG_LSB +: 4] : map_data[BG_LSB +: 4];
      b_col_q <= a_col_q;
      b_hs_q  <= a_hs_q;
      b_vs_q  <= a_vs_q;
      b_br_q  <= a_br_q;
    end
  end

  logic     pix;
  pal_idx_t rd_idx;
  rgb332_t  rd_data, rgb_d;
  rgb332_t  rgb_q;
  logic     hs_q, vs_q, br_q;

  always_comb begin
    pix    = glyph_data[3'd7 - b_col_q];
    rd_idx = pix ? b_fg_q : b_bg_q;
    rgb_d  = b_br_q ? rd_data : 8'h00;
  end

  vga_palette u_palette (
    .clock_i   (clock),
    .clear_i   (clear),
    .we_i      (pal_we),
    .wr_idx_i  (pal_idx),
    .wr_data_i (pal_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      rgb_q <= 8'h00;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      br_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= b_hs_q;
      vs_q  <= b_vs_q;
      br_q  <= b_br_q;
    end
  end

  assign rgb    = rgb_q;
  assign hSync  = hs_q;
  assign vSync  = vs_q;
  assign bright = br_q;

endmodule
